iod_delay_line_ctrl: RTL and testbench
======================================

Name: iod_delay_line_ctrl

Overview:
- Sequences the dynamic delay-line controls (MOVE / DIRECTION / LOAD) of up to NUM_LANES DDR PHY IOD lanes from one fabric command port.
- Accepts one step-count or load request at a time, emits correctly spaced single-cycle MOVE pulses to the addressed lane, and stops early on OUT_OF_RANGE.
- Sits between PHY training logic and the IOD blocks in the DDRPHY hierarchy, on the FAB_CLK domain.

Parameters:
- NUM_LANES, 8, number of IOD lanes controlled.
- LANE_W, 3, width of the lane index; must satisfy 2**LANE_W >= NUM_LANES.
- STEP_W, 8, width of the step count.
- GAP_CYCLES, 4, idle cycles after each MOVE pulse before the next pulse or completion (>=1).
- LOAD_HOLD, 2, cycles LOAD is held high (>=1).

Ports:
- FAB_CLK in 1: sole clock.
- ARST_N in 1: asynchronous active-low reset.
- REQ_VALID in 1: request valid.
- REQ_READY out 1: request accepted when VALID&READY.
- REQ_OP in 2: 00 = increment, 01 = decrement, 10 = load default, 11 = illegal.
- REQ_LANE in LANE_W: target lane.
- REQ_STEPS in STEP_W: number of MOVE pulses; ignored for load.
- DONE out 1: single-cycle completion pulse.
- DONE_STEPS out STEP_W: MOVE pulses actually issued; valid with DONE.
- DONE_OOR out 1: request terminated by OUT_OF_RANGE; valid with DONE.
- DONE_ERR out 1: illegal op or lane; valid with DONE.
- BUSY out 1: high in every state except IDLE.
- DELAY_LINE_MOVE out NUM_LANES: per-lane move pulse.
- DELAY_LINE_DIRECTION out NUM_LANES: per-lane direction, 1 = increment.
- DELAY_LINE_LOAD out NUM_LANES: per-lane load strobe.
- DELAY_LINE_OUT_OF_RANGE in NUM_LANES: per-lane out-of-range flag from the IOD.

Behaviour:
- Reset (asynchronous, any state): FSM goes to IDLE. All of MOVE, DIRECTION, LOAD, DONE, DONE_STEPS, DONE_OOR, DONE_ERR and BUSY are 0. REQ_READY is 0 while ARST_N is low and 1 in the first cycle after release. An in-flight request is discarded with no DONE.
- All outputs are registered. At most one lane bit of MOVE or LOAD is high in any cycle.
- FSM states: IDLE, SETUP, MOVE, GAP, LOAD, DONE.
- IDLE: REQ_READY = 1. On accept, capture op, lane and steps, and clear the step counter.
  - Illegal op or lane >= NUM_LANES -> DONE with ERR = 1, and no strobes are issued.
  - Op = load -> LOAD.
  - Inc/dec with steps = 0 -> DONE with 0 steps.
  - Otherwise -> SETUP.
- SETUP (1 cycle): DIRECTION[lane] is set per op. DIRECTION bits hold their last value until rewritten. -> MOVE.
- MOVE (1 cycle): MOVE[lane] = 1, step counter +1. -> GAP.
- GAP (GAP_CYCLES cycles): OUT_OF_RANGE[lane] is sampled in the final GAP cycle.
  - If sampled high -> DONE with OOR = 1.
  - Else, if counter == requested steps -> DONE.
  - Else -> MOVE.
- LOAD: LOAD[lane] = 1 for LOAD_HOLD cycles. -> DONE with steps 0; OOR and ERR are 0.
- DONE (1 cycle): DONE = 1 and the status outputs are driven. -> IDLE. Status outputs return to 0 in IDLE.
- Latency:
  - Inc/dec of N steps accepted at cycle T: MOVE k at T+2+k*(1+GAP_CYCLES), DONE at T+2+N*(1+GAP_CYCLES).
  - Load: DONE at T+1+LOAD_HOLD+1.
  - Error / zero steps: DONE at T+1.
- Back-to-back requests: the earliest next accept is the cycle after DONE.
- OUT_OF_RANGE already high before the first move: one pulse is still issued, then the request terminates with OOR = 1 and steps = 1.
- The step counter is STEP_W wide and never wraps, because it is bounded by the request.

Decomposition:
- Shared package iod_dlc_pkg holds:
  - the op encodings (OP_INC, OP_DEC, OP_LOAD, OP_ILLEGAL);
  - the FSM state enum;
  - the direction constant DIR_INC = 1.
- Single module; no sub-module is warranted. The per-lane one-hot decode is an inline function in the package.

Test Plan:
- Inc, lane 2, steps 3, GAP 4, accept at T=10 -> MOVE[2] at cycles 12, 17, 22; DIRECTION[2] = 1 from 12; DONE at 27 with STEPS = 3, OOR = 0.
- Dec, lane 5, steps 10; OUT_OF_RANGE[5] raised after the 4th pulse -> exactly 4 pulses, DIRECTION[5] = 0, DONE with STEPS = 4, OOR = 1.
- Load, lane 7, accept at T=0 -> LOAD[7] high at cycles 1-2, no MOVE, DONE at 4 with STEPS = 0.
- Lane 9 (NUM_LANES = 8) and op 11 requests -> DONE at T+1 with ERR = 1, no strobes; steps = 0 inc -> DONE at T+1 with STEPS = 0, ERR = 0.
- ARST_N low during the 2nd GAP of a 5-step request -> all outputs 0 immediately, no DONE. After release REQ_READY = 1 and a new 1-step request completes normally.
- Back-to-back inc on lane 0 then dec on lane 1, with VALID held high -> second accepted the cycle after the first DONE, DIRECTION[0] stays 1, and MOVE is never high on two lanes at once.

Source files
------------

// File: rtl/iod_dlc_pkg.sv
// Shared op encodings, FSM states and lane decode for the IOD delay-line sequencer.
package iod_dlc_pkg;

  localparam logic [1:0] OP_INC     = 2'b00;
  localparam logic [1:0] OP_DEC     = 2'b01;
  localparam logic [1:0] OP_LOAD    = 2'b10;
  localparam logic [1:0] OP_ILLEGAL = 2'b11;

  localparam logic DIR_INC   = 1'b1;
  localparam int   MAX_LANES = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_MOVE,
    ST_GAP,
    ST_LOAD,
    ST_DONE
  } state_t;

  function automatic logic [MAX_LANES-1:0] lane_onehot(input logic [4:0] lane);
    return MAX_LANES'(1) << lane;
  endfunction

endpackage

// File: rtl/iod_delay_line_ctrl.sv
// Sequences MOVE/DIRECTION/LOAD strobes to one IOD lane per request; one request in flight,
// REQ_READY only in IDLE. Inc/dec DONE at T+2+N*(1+GAP_CYCLES), load at T+2+LOAD_HOLD, error/zero at T+1.
module iod_delay_line_ctrl
  import iod_dlc_pkg::*;
#(
  parameter int NUM_LANES  = 8,
  parameter int LANE_W     = 3,
  parameter int STEP_W     = 8,
  parameter int GAP_CYCLES = 4,
  parameter int LOAD_HOLD  = 2
) (
  input  logic                 FAB_CLK,
  input  logic                 ARST_N,
  input  logic                 REQ_VALID,
  output logic                 REQ_READY,
  input  logic [1:0]           REQ_OP,
  input  logic [LANE_W-1:0]    REQ_LANE,
  input  logic [STEP_W-1:0]    REQ_STEPS,
  output logic                 DONE,
  output logic [STEP_W-1:0]    DONE_STEPS,
  output logic                 DONE_OOR,
  output logic                 DONE_ERR,
  output logic                 BUSY,
  output logic [NUM_LANES-1:0] DELAY_LINE_MOVE,
  output logic [NUM_LANES-1:0] DELAY_LINE_DIRECTION,
  output logic [NUM_LANES-1:0] DELAY_LINE_LOAD,
  input  logic [NUM_LANES-1:0] DELAY_LINE_OUT_OF_RANGE
);

  localparam int TMR_MAX = (GAP_CYCLES > LOAD_HOLD) ? GAP_CYCLES : LOAD_HOLD;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  state_t               state;
  logic [LANE_W-1:0]    lane_q;
  logic                 dir_inc_q;
  logic [STEP_W-1:0]    steps_q;
  logic [STEP_W-1:0]    step_cnt;
  logic [TMR_W-1:0]     tmr;
  logic                 ready_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 done_oor_q;
  logic                 done_err_q;
  logic [STEP_W-1:0]    done_steps_q;
  logic [NUM_LANES-1:0] move_q;
  logic [NUM_LANES-1:0] dir_q;
  logic [NUM_LANES-1:0] load_q;

  logic [NUM_LANES-1:0] lane_oh;
  logic [NUM_LANES-1:0] req_lane_oh;
  logic                 req_err;
  logic                 req_incdec;
  logic                 lane_oor;
  logic                 last_gap;

  assign lane_oh     = NUM_LANES'(lane_onehot(5'(lane_q)));
  assign req_lane_oh = NUM_LANES'(lane_onehot(5'(REQ_LANE)));
  assign req_err     = (REQ_OP == OP_ILLEGAL) || (32'(REQ_LANE) >= 32'(NUM_LANES));
  assign req_incdec  = (REQ_OP == OP_INC) || (REQ_OP == OP_DEC);
  // Only the addressed lane's range flag can end a request.
  assign lane_oor    = |(DELAY_LINE_OUT_OF_RANGE & lane_oh);
  assign last_gap    = (tmr == TMR_W'(GAP_CYCLES - 1));

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state        <= ST_IDLE;
      lane_q       <= '0;
      dir_inc_q    <= 1'b0;
      steps_q      <= '0;
      step_cnt     <= '0;
      tmr          <= '0;
      ready_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      done_steps_q <= '0;
      done_oor_q   <= 1'b0;
      done_err_q   <= 1'b0;
      move_q       <= '0;
      dir_q        <= '0;
      load_q       <= '0;
    end else begin
      move_q <= '0;
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (REQ_VALID && ready_q) begin
            lane_q    <= REQ_LANE;
            dir_inc_q <= (REQ_OP == OP_DEC) ? ~DIR_INC : DIR_INC;
            steps_q   <= REQ_STEPS;
            step_cnt  <= '0;
            tmr       <= '0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
            if (req_err) begin
              state      <= ST_DONE;
              done_q     <= 1'b1;
              done_err_q <= 1'b1;
            end else if (REQ_OP == OP_LOAD) begin
              state  <= ST_LOAD;
              load_q <= req_lane_oh;
            end else if (req_incdec && (REQ_STEPS == '0)) begin
              state  <= ST_DONE;
              done_q <= 1'b1;
            end else begin
              state <= ST_SETUP;
            end
          end else begin
            ready_q <= 1'b1;
          end
        end
        ST_SETUP: begin
          dir_q    <= (dir_inc_q == DIR_INC) ? (dir_q | lane_oh) : (dir_q & ~lane_oh);
          move_q   <= lane_oh;
          step_cnt <= step_cnt + STEP_W'(1);
          state    <= ST_MOVE;
        end
        ST_MOVE: begin
          tmr   <= '0;
          state <= ST_GAP;
        end
        ST_GAP: begin
          if (last_gap) begin
            if (lane_oor || (step_cnt == steps_q)) begin
              state        <= ST_DONE;
              done_q       <= 1'b1;
              done_steps_q <= step_cnt;
              done_oor_q   <= lane_oor;
            end else begin
              move_q   <= lane_oh;
              step_cnt <= step_cnt + STEP_W'(1);
              state    <= ST_MOVE;
            end
          end else begin
            tmr <= tmr + TMR_W'(1);
          end
        end
        ST_LOAD: begin
          // LOAD drops after LOAD_HOLD cycles; one quiet cycle follows before DONE.
          if (tmr == TMR_W'(LOAD_HOLD)) begin
            state  <= ST_DONE;
            done_q <= 1'b1;
          end else begin
            if (tmr == TMR_W'(LOAD_HOLD - 1)) load_q <= '0;
            tmr <= tmr + TMR_W'(1);
          end
        end
        ST_DONE: begin
          done_steps_q <= '0;
          done_oor_q   <= 1'b0;
          done_err_q   <= 1'b0;
          busy_q       <= 1'b0;
          ready_q      <= 1'b1;
          state        <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign REQ_READY            = ready_q;
  assign BUSY                 = busy_q;
  assign DONE                 = done_q;
  assign DONE_STEPS           = done_steps_q;
  assign DONE_OOR             = done_oor_q;
  assign DONE_ERR             = done_err_q;
  assign DELAY_LINE_MOVE      = move_q;
  assign DELAY_LINE_DIRECTION = dir_q;
  assign DELAY_LINE_LOAD      = load_q;

endmodule

// File: tb/tb_iod_delay_line_ctrl.sv
// Randomized bench for iod_delay_line_ctrl against a timeline model of each request.
module tb_iod_delay_line_ctrl;

  localparam int NL = 8;
  localparam int LW = 4;
  localparam int SW = 8;
  localparam int G  = 4;
  localparam int LH = 2;

  logic          FAB_CLK = 1'b0;
  logic          ARST_N;
  logic          REQ_VALID;
  logic          REQ_READY;
  logic [1:0]    REQ_OP;
  logic [LW-1:0] REQ_LANE;
  logic [SW-1:0] REQ_STEPS;
  logic          DONE;
  logic [SW-1:0] DONE_STEPS;
  logic          DONE_OOR;
  logic          DONE_ERR;
  logic          BUSY;
  logic [NL-1:0] DELAY_LINE_MOVE;
  logic [NL-1:0] DELAY_LINE_DIRECTION;
  logic [NL-1:0] DELAY_LINE_LOAD;
  logic [NL-1:0] DELAY_LINE_OUT_OF_RANGE;

  iod_delay_line_ctrl #(
    .NUM_LANES(NL), .LANE_W(LW), .STEP_W(SW), .GAP_CYCLES(G), .LOAD_HOLD(LH)
  ) dut (
    .FAB_CLK(FAB_CLK), .ARST_N(ARST_N),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_OP(REQ_OP),
    .REQ_LANE(REQ_LANE), .REQ_STEPS(REQ_STEPS),
    .DONE(DONE), .DONE_STEPS(DONE_STEPS), .DONE_OOR(DONE_OOR), .DONE_ERR(DONE_ERR),
    .BUSY(BUSY),
    .DELAY_LINE_MOVE(DELAY_LINE_MOVE), .DELAY_LINE_DIRECTION(DELAY_LINE_DIRECTION),
    .DELAY_LINE_LOAD(DELAY_LINE_LOAD), .DELAY_LINE_OUT_OF_RANGE(DELAY_LINE_OUT_OF_RANGE)
  );

  always #5 FAB_CLK = ~FAB_CLK;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int multi_hot = 0;
  int last_acc, last_done;
  logic [NL-1:0] exp_dir;

  always @(posedge FAB_CLK) cyc <= cyc + 1;

  always @(negedge FAB_CLK)
    if ($countones(DELAY_LINE_MOVE) > 1 || $countones(DELAY_LINE_LOAD) > 1 ||
        (|DELAY_LINE_MOVE && |DELAY_LINE_LOAD))
      multi_hot++;

  task automatic check(input string tag, input longint got, input longint want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, got, want);
    end
  endtask

  // Issue one request (called at a negedge) and check its full timeline against the model.
  task automatic run_req(input logic [1:0] op, input int lane, input int steps,
                         input int oor_after, input bit keep, input string tag);
    logic [NL-1:0] tmask;
    bit err, oor_on, done_seen, exp_oor, hit;
    int exp_lat, exp_steps, exp_loads, pe, rel;
    int n_mov, n_load, mov_late, load_bad, other, busy_lo;
    int got_lat, got_steps, got_oor, got_err;

    tmask = (lane < NL) ? (NL'(1) << lane) : '0;
    err = (op == 2'b11) || (lane >= NL);
    exp_oor = 1'b0; exp_steps = 0; exp_loads = 0;
    if (err) exp_lat = 1;
    else if (op == 2'b10) begin exp_lat = LH + 2; exp_loads = LH; end
    else if (steps == 0) exp_lat = 1;
    else begin
      hit = (oor_after >= 0) && (oor_after <= steps);
      pe = hit ? ((oor_after == 0) ? 1 : oor_after) : steps;
      exp_oor = hit;
      exp_steps = pe;
      exp_lat = 2 + pe * (1 + G);
      exp_dir[lane] = (op == 2'b00);
    end

    oor_on = (oor_after == 0);
    REQ_VALID = 1'b1; REQ_OP = op; REQ_LANE = LW'(lane); REQ_STEPS = SW'(steps);
    DELAY_LINE_OUT_OF_RANGE = (NL'($urandom) & ~tmask) | (oor_on ? tmask : '0);
    rel = 0;
    while (!REQ_READY && rel < 200) begin @(negedge FAB_CLK); rel++; end
    if (!REQ_READY) begin
      check({tag, "_accept_timeout"}, 0, 1);
      REQ_VALID = 1'b0;
      return;
    end
    last_acc = cyc;

    n_mov = 0; n_load = 0; mov_late = 0; load_bad = 0; other = 0; busy_lo = 0;
    done_seen = 1'b0; got_lat = 0; got_steps = 0; got_oor = 0; got_err = 0;
    for (int r = 1; r <= 400 && !done_seen; r++) begin
      @(negedge FAB_CLK);
      if (!keep) REQ_VALID = 1'b0;
      if (!BUSY) busy_lo++;
      if ((DELAY_LINE_MOVE & ~tmask) != '0) other++;
      if ((DELAY_LINE_LOAD & ~tmask) != '0) other++;
      if ((DELAY_LINE_MOVE & tmask) != '0) begin
        n_mov++;
        if (r != 2 + (n_mov - 1) * (1 + G)) mov_late++;
        if (n_mov == oor_after) oor_on = 1'b1;
      end
      if ((DELAY_LINE_LOAD & tmask) != '0) begin
        n_load++;
        if (r > LH) load_bad++;
      end
      DELAY_LINE_OUT_OF_RANGE = (NL'($urandom) & ~tmask) | (oor_on ? tmask : '0);
      if (DONE) begin
        done_seen = 1'b1;
        got_lat = r; got_steps = int'(DONE_STEPS); got_oor = int'(DONE_OOR); got_err = int'(DONE_ERR);
      end
    end
    last_done = cyc;

    if (!done_seen) check({tag, "_done_timeout"}, 0, 1);
    else begin
      check({tag, "_latency"}, got_lat, exp_lat);
      check({tag, "_done_steps"}, got_steps, exp_steps);
      check({tag, "_done_oor"}, got_oor, exp_oor);
      check({tag, "_done_err"}, got_err, err);
      check({tag, "_moves"}, n_mov, exp_steps);
      check({tag, "_move_timing"}, mov_late, 0);
      check({tag, "_loads"}, n_load, exp_loads);
      check({tag, "_load_window"}, load_bad, 0);
      check({tag, "_wrong_lane"}, other, 0);
      check({tag, "_busy"}, busy_lo, 0);
      check({tag, "_direction"}, DELAY_LINE_DIRECTION, exp_dir);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int n, d, dn, lane, steps, oor_after;
    logic [1:0] op;

    ARST_N = 1'b1; REQ_VALID = 1'b0; REQ_OP = '0; REQ_LANE = '0; REQ_STEPS = '0;
    DELAY_LINE_OUT_OF_RANGE = '0; exp_dir = '0;
    #2 ARST_N = 1'b0;
    #20 check("rst_outputs", {DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, DELAY_LINE_LOAD, DONE,
                             DONE_STEPS, DONE_OOR, DONE_ERR, BUSY, REQ_READY}, 0);
    @(negedge FAB_CLK); #2 ARST_N = 1'b1;
    @(negedge FAB_CLK);
    check("rdy_after_rst", REQ_READY, 1);
    check("busy_after_rst", BUSY, 0);

    run_req(2'b00, 2, 3, -1, 1'b0, "inc3");
    run_req(2'b01, 5, 10, 4, 1'b0, "dec_oor");
    run_req(2'b10, 7, 0, -1, 1'b0, "load");
    run_req(2'b00, 9, 3, -1, 1'b0, "lane9");
    run_req(2'b11, 1, 2, -1, 1'b0, "op_ill");
    run_req(2'b00, 4, 0, -1, 1'b0, "zero");
    run_req(2'b00, 6, 3, 0, 1'b0, "oor_pre");

    // Reset in the middle of the second GAP of a 5-step request.
    REQ_VALID = 1'b1; REQ_OP = 2'b00; REQ_LANE = LW'(3); REQ_STEPS = SW'(5);
    DELAY_LINE_OUT_OF_RANGE = '0;
    n = 0;
    while (!REQ_READY && n < 50) begin @(negedge FAB_CLK); n++; end
    @(negedge FAB_CLK); REQ_VALID = 1'b0;
    n = 0; d = 0;
    while (n < 2 && d < 100) begin
      @(negedge FAB_CLK); d++;
      if (DELAY_LINE_MOVE[3]) n++;
    end
    check("rst_two_moves_seen", n, 2);
    @(negedge FAB_CLK); #2 ARST_N = 1'b0;
    #1 check("rst_mid_outputs", {DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, DELAY_LINE_LOAD, DONE,
                                DONE_STEPS, DONE_OOR, DONE_ERR, BUSY, REQ_READY}, 0);
    exp_dir = '0;
    dn = 0;
    for (int i = 0; i < 3; i++) begin @(negedge FAB_CLK); if (DONE) dn++; end
    #2 ARST_N = 1'b1;
    for (int i = 0; i < 3; i++) begin @(negedge FAB_CLK); if (DONE) dn++; end
    check("rst_no_done", dn, 0);
    check("rst_rdy_release", REQ_READY, 1);
    run_req(2'b00, 3, 1, -1, 1'b0, "post_rst");

    // VALID held high across a pair of requests.
    run_req(2'b00, 0, 2, -1, 1'b1, "b2b_a");
    d = last_done;
    run_req(2'b01, 1, 2, -1, 1'b0, "b2b_b");
    check("b2b_accept_gap", last_acc - d, 1);

    for (int i = 0; i < 30; i++) begin
      op = 2'($urandom_range(0, 3));
      lane = int'($urandom_range(0, 9));
      steps = int'($urandom_range(0, 6));
      oor_after = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, steps)) : -1;
      run_req(op, lane, steps, oor_after, 1'b0, "rnd");
      n = int'($urandom_range(0, 2));
      for (int k = 0; k < n; k++) @(negedge FAB_CLK);
    end

    check("one_hot_strobes", multi_hot, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
